button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable synchronized samples needed to accept a level change (legal range 1..2^20-1).
REQ-002 Parameter REPEAT_DELAY, default 50000000, is the cycles from an accepted press to the first auto-repeat pulse; 0 disables auto-repeat.
REQ-003 Parameter REPEAT_PERIOD, default 10000000, is the cycles between later auto-repeat pulses (legal range 1..2^32-1).
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port btn_raw, input, 5: asynchronous board buttons; bit order {bottom, top, right, center, left}, bit 0 = left.
REQ-007 Port btn_level, output, 5: debounced button state, 1 = pressed.
REQ-008 Port btn_press, output, 5: one-cycle pulse on each accepted press.
REQ-009 Port btn_release, output, 5: one-cycle pulse on each accepted release.
REQ-010 Port btn_repeat, output, 5: one-cycle auto-repeat pulse while held.

Function
REQ-011 Each bit passes through a two-flop synchronizer; no other logic reads btn_raw.
REQ-012 Each bit has an independent FSM with states LOW, RISING, HIGH and FALLING, and a debounce counter cnt.
REQ-013 LOW: sync=1 -> RISING with cnt=1; otherwise stay with cnt=0.
REQ-014 RISING: sync=0 -> LOW with cnt=0; sync=1 with cnt=DEBOUNCE_CYCLES-1 -> HIGH; otherwise cnt+1.
REQ-015 HIGH: sync=0 -> FALLING with cnt=1; otherwise stay.
REQ-016 FALLING: sync=1 -> HIGH; sync=0 with cnt=DEBOUNCE_CYCLES-1 -> LOW; otherwise cnt+1.
REQ-017 If DEBOUNCE_CYCLES=1, LOW goes straight to HIGH and HIGH goes straight to LOW on the first differing sample; RISING and FALLING are never entered.
REQ-018 btn_level is 1 in HIGH and FALLING and 0 in LOW and RISING; it is registered and changes on the same edge as the state.
REQ-019 btn_press pulses for exactly the first cycle btn_level=1; btn_release pulses for exactly the first cycle btn_level=0 after being 1.
REQ-020 Latency: a raw edge that stays stable appears on btn_level exactly 2+DEBOUNCE_CYCLES cycles after the first edge that samples it.
REQ-021 Any glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no change and no pulses.
REQ-022 Repeat counter rcnt is 32 bits, cleared on the press edge, and increments only while in HIGH.
REQ-023 rcnt holds its value in FALLING, so a rejected release glitch resumes the repeat schedule without restarting it.
REQ-024 btn_repeat pulses when rcnt reaches REPEAT_DELAY; rcnt then reloads to REPEAT_DELAY-REPEAT_PERIOD, giving pulses every REPEAT_PERIOD cycles.
REQ-025 btn_repeat never coincides with btn_press and is never asserted outside HIGH.
REQ-026 The five channels are fully independent; simultaneous events on several bits produce simultaneous pulses.

Reset
REQ-027 While rst=1 at a clock edge: all FSMs go to LOW, cnt, rcnt and the synchronizer flops clear, and all outputs are 0 on the next cycle.
REQ-028 Reset mid-press produces no btn_release pulse.
REQ-029 A button held through reset release is accepted as a new press after 2+DEBOUNCE_CYCLES cycles.

Structure
REQ-030 Package button_pkg holds the FSM state enum (LOW/RISING/HIGH/FALLING), NUM_BTNS=5, and the localparam bit indices BTN_LEFT=0, BTN_CENTER=1, BTN_RIGHT=2, BTN_TOP=3, BTN_BOTTOM=4.
REQ-031 Sub-module button_channel implements the synchronizer, FSM and repeat logic for one bit; button_conditioner instantiates it NUM_BTNS times with a generate loop.
REQ-032 button_conditioner feeds mips_top's left_btn, center_btn, right_btn, top_btn and bottom_btn inputs; the CPU reset path uses btn_level[BTN_TOP].

Verification
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
REQ-033 Reset: hold rst=1 for 3 cycles with btn_raw=5'h1F -> all outputs 0; after release, btn_level=5'h1F appears 6 cycles later with btn_press=5'h1F for 1 cycle.
REQ-034 Clean press of bit 0 -> btn_level[0] rises 6 cycles after the edge; btn_press[0] asserts for exactly 1 cycle; btn_release[0] follows 6 cycles after the raw falling edge.
REQ-035 Bounce: toggle btn_raw[1] 1,0,1,0 at 1-cycle intervals, then hold at 1 -> exactly one btn_press[1], 6 cycles after the final rising edge.
REQ-036 Hold bit 3 for 60 cycles after acceptance -> btn_repeat[3] at +20, +28, +36, +44, +52 cycles; a 2-cycle release glitch at +30 shifts the remaining pulses later by the glitch length, with no release pulse.
REQ-037 Simultaneous press of bits 2 and 4, with rst asserted 3 cycles after acceptance -> both btn_press bits on the same cycle; after reset all outputs are 0 and no btn_release pulse occurs.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the five-button conditioner: channel count, bit indices and debounce FSM states.
package button_pkg;

    localparam int unsigned NUM_BTNS   = 5;

    localparam int unsigned BTN_LEFT   = 0;
    localparam int unsigned BTN_CENTER = 1;
    localparam int unsigned BTN_RIGHT  = 2;
    localparam int unsigned BTN_TOP    = 3;
    localparam int unsigned BTN_BOTTOM = 4;

    localparam int unsigned DEB_CNT_W  = 20;
    localparam int unsigned RPT_CNT_W  = 32;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        RISING  = 2'd1,
        HIGH    = 2'd2,
        FALLING = 2'd3
    } btn_state_e;

endpackage

// File: rtl/button_channel.sv
// One button bit: two-flop synchronizer, debounce FSM, press/release edge pulses and auto-repeat.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST   = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_CNT_W-1:0] RPT_DELAY  = RPT_CNT_W'(REPEAT_DELAY);
    localparam logic [RPT_CNT_W-1:0] RPT_RELOAD = RPT_CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam bit                   RPT_EN     = (REPEAT_DELAY != 0);
    localparam bit                   DEB_SINGLE = (DEBOUNCE_CYCLES == 1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    btn_state_e           state_q, state_d;
    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
    logic [RPT_CNT_W-1:0] rcnt_q, rcnt_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 repeat_q, repeat_d;
    logic [RPT_CNT_W-1:0] rcnt_inc;

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        rcnt_inc  = rcnt_q + RPT_CNT_W'(1);
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;

        unique case (state_q)
            LOW: begin
                if (sync2_q) begin
                    if (DEB_SINGLE) begin
                        state_d = HIGH;
                    end else begin
                        state_d = RISING;
                        cnt_d   = DEB_CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            RISING: begin
                if (!sync2_q) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + DEB_CNT_W'(1);
                end
            end
            HIGH: begin
                if (!sync2_q) begin
                    if (DEB_SINGLE) begin
                        state_d = LOW;
                    end else begin
                        state_d = FALLING;
                        cnt_d   = DEB_CNT_W'(1);
                    end
                end
            end
            FALLING: begin
                if (sync2_q) begin
                    state_d = HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + DEB_CNT_W'(1);
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase

        level_d   = (state_d == HIGH) || (state_d == FALLING);
        press_d   = level_d && !level_q;
        release_d = !level_d && level_q;

        // A pulse that falls due while leaving HIGH is held back until HIGH resumes.
        if (press_d) begin
            rcnt_d = '0;
        end else if (state_q == HIGH) begin
            if (RPT_EN && (rcnt_inc == RPT_DELAY)) begin
                if (state_d == HIGH) begin
                    repeat_d = 1'b1;
                    rcnt_d   = RPT_RELOAD;
                end
            end else begin
                rcnt_d = rcnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= LOW;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Board button front end: five independent debounce/auto-repeat channels feeding the CPU button inputs.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table, repeat/glitch and reset sequences, random run against a reference model.
module tb_button_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_level, btn_press, btn_release, btn_repeat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    typedef struct {
        logic       rst;
        logic [4:0] raw;
        int         n;
        logic [4:0] lvl;
        logic [4:0] prs;
        logic [4:0] rel;
        logic [4:0] rpt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [4:0] raw, input int n,
                                input logic [4:0] lvl, input logic [4:0] prs,
                                input logic [4:0] rel, input logic [4:0] rpt);
        vec_t v;
        v.rst = r; v.raw = raw; v.n = n;
        v.lvl = lvl; v.prs = prs; v.rel = rel; v.rpt = rpt;
        return v;
    endfunction

    task automatic check(input string name, input logic [4:0] lvl, input logic [4:0] prs,
                         input logic [4:0] rel, input logic [4:0] rpt);
        total++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== {lvl, prs, rel, rpt}) begin
            bad++;
            $display("FAIL %s @%0t: got lvl=%h prs=%h rel=%h rpt=%h, want lvl=%h prs=%h rel=%h rpt=%h",
                     name, $time, btn_level, btn_press, btn_release, btn_repeat, lvl, prs, rel, rpt);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the falling edge after n rising edges.
    task automatic step(input logic r, input logic [4:0] raw, input int n);
        rst     = r;
        btn_raw = raw;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Hold bit 3; optional 2-cycle raw release glitch starting at cycle glitch_at after acceptance.
    task automatic hold_test(input string name, input int glitch_at);
        int  eff;
        logic [4:0] rpt;
        step(1'b0, 5'h08, 6);
        check({name, "_press"}, 5'h08, 5'h08, 5'h00, 5'h00);
        for (int k = 1; k <= 64; k++) begin
            if (glitch_at > 0 && k == glitch_at)     btn_raw = 5'h00;
            if (glitch_at > 0 && k == glitch_at + 2) btn_raw = 5'h08;
            @(posedge clk);
            @(negedge clk);
            // Glitch cycles seen 2 samples late do not advance the schedule.
            eff = (glitch_at > 0 && k >= glitch_at + 4) ? k - 2 : k;
            rpt = (eff >= int'(RD) && ((eff - int'(RD)) % int'(RP)) == 0) ? 5'h08 : 5'h00;
            check($sformatf("%s_k%0d", name, k), 5'h08, 5'h00, 5'h00, rpt);
        end
        step(1'b0, 5'h00, 5);
        check({name, "_relwait"}, 5'h08, 5'h00, 5'h00, 5'h00);
        step(1'b0, 5'h00, 1);
        check({name, "_release"}, 5'h00, 5'h00, 5'h08, 5'h00);
        step(1'b0, 5'h00, 1);
        check({name, "_idle"}, 5'h00, 5'h00, 5'h00, 5'h00);
    endtask

    // Reference model: a level flips once DB consecutive synchronized samples disagree with it.
    logic [4:0] m_d1, m_d2;
    logic       m_lvl  [5];
    logic       m_last [5];
    int         m_run  [5];
    int         m_h    [5];

    function automatic bit is_pulse(input int n);
        return (n >= int'(RD)) && (((n - int'(RD)) % int'(RP)) == 0);
    endfunction

    task automatic model_reset();
        m_d1 = '0;
        m_d2 = '0;
        for (int b = 0; b < 5; b++) begin
            m_lvl[b] = 1'b0; m_last[b] = 1'b0; m_run[b] = 0; m_h[b] = 0;
        end
    endtask

    task automatic model_edge(input logic [4:0] raw, output logic [4:0] l, output logic [4:0] p,
                              output logic [4:0] r, output logic [4:0] q);
        logic [4:0] sync;
        logic       nl, prev_high, now_high;
        int         nh;
        sync = m_d2;
        m_d2 = m_d1;
        m_d1 = raw;
        p = '0; r = '0; q = '0; l = '0;
        for (int b = 0; b < 5; b++) begin
            prev_high = m_lvl[b] && m_last[b];
            if (sync[b] != m_lvl[b]) m_run[b]++;
            else                     m_run[b] = 0;
            nl = m_lvl[b];
            if (m_run[b] >= int'(DB)) begin
                nl = ~m_lvl[b];
                m_run[b] = 0;
            end
            now_high = nl && sync[b];
            if (!m_lvl[b] && nl) begin
                p[b] = 1'b1;
                m_h[b] = 0;
            end else if (prev_high) begin
                nh = m_h[b] + 1;
                if (!(is_pulse(nh) && !now_high)) begin
                    m_h[b] = nh;
                    if (is_pulse(nh)) q[b] = 1'b1;
                end
            end
            if (m_lvl[b] && !nl) r[b] = 1'b1;
            m_lvl[b]  = nl;
            m_last[b] = sync[b];
            l[b]      = nl;
        end
    endtask

    initial begin
        logic [4:0] el, ep, er, eq, cur;
        int hold [5];

        rst     = 1'b1;
        btn_raw = 5'h1F;
        @(negedge clk);

        tbl.push_back(mk(1'b1, 5'h1F, 3, 5'h00, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h1F, 5, 5'h00, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h1F, 1, 5'h1F, 5'h1F, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h1F, 1, 5'h1F, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h00, 5, 5'h1F, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h00, 1, 5'h00, 5'h00, 5'h1F, 5'h00));
        tbl.push_back(mk(1'b0, 5'h00, 1, 5'h00, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h01, 5, 5'h00, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h01, 1, 5'h01, 5'h01, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h01, 1, 5'h01, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h00, 5, 5'h01, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h00, 1, 5'h00, 5'h00, 5'h01, 5'h00));
        tbl.push_back(mk(1'b0, 5'h00, 1, 5'h00, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h02, 1, 5'h00, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h00, 1, 5'h00, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h02, 1, 5'h00, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h00, 1, 5'h00, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h02, 5, 5'h00, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h02, 1, 5'h02, 5'h02, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h02, 1, 5'h02, 5'h00, 5'h00, 5'h00));
        tbl.push_back(mk(1'b0, 5'h00, 6, 5'h00, 5'h00, 5'h02, 5'h00));
        tbl.push_back(mk(1'b0, 5'h00, 1, 5'h00, 5'h00, 5'h00, 5'h00));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].raw, tbl[i].n);
            check($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].rpt);
        end

        hold_test("hold", 0);
        hold_test("glitch", 30);

        // Simultaneous press on bits 2 and 4, then reset while still held.
        step(1'b0, 5'h14, 5);
        check("dual_wait", 5'h00, 5'h00, 5'h00, 5'h00);
        step(1'b0, 5'h14, 1);
        check("dual_press", 5'h14, 5'h14, 5'h00, 5'h00);
        step(1'b0, 5'h14, 2);
        check("dual_held", 5'h14, 5'h00, 5'h00, 5'h00);
        step(1'b1, 5'h14, 1);
        check("dual_rst", 5'h00, 5'h00, 5'h00, 5'h00);
        step(1'b1, 5'h14, 2);
        check("dual_rst_hold", 5'h00, 5'h00, 5'h00, 5'h00);
        step(1'b0, 5'h14, 5);
        check("dual_no_release", 5'h00, 5'h00, 5'h00, 5'h00);
        step(1'b0, 5'h14, 1);
        check("dual_repress", 5'h14, 5'h14, 5'h00, 5'h00);
        step(1'b0, 5'h00, 6);
        check("dual_release", 5'h00, 5'h00, 5'h14, 5'h00);
        step(1'b0, 5'h00, 1);
        check("dual_idle", 5'h00, 5'h00, 5'h00, 5'h00);

        // Random per-bit hold lengths: mostly bounces, some long holds that reach auto-repeat.
        step(1'b1, 5'h00, 2);
        check("rand_reset", 5'h00, 5'h00, 5'h00, 5'h00);
        model_reset();
        rst = 1'b0;
        cur = '0;
        for (int b = 0; b < 5; b++) hold[b] = int'($urandom_range(1, 30));
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 5; b++) begin
                if (hold[b] == 0) begin
                    cur[b]  = ~cur[b];
                    hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(25, 60))
                                                          : int'($urandom_range(1, 6));
                end
                hold[b]--;
            end
            btn_raw = cur;
            @(posedge clk);
            model_edge(cur, el, ep, er, eq);
            @(negedge clk);
            check($sformatf("rand%0d", c), el, ep, er, eq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
